// File: rtl/nx_fifo_pop_stage.sv
// nx_fifo_pop_stage
// Read-side staging block for a show-ahead nx_fifo. Words are popped from the
// FIFO into a 2-entry buffer and presented on a valid/ready stream whose
// valid/data come from registers only. The FIFO pop strobe depends on the
// buffer count and FIFO status, never on the consumer's ready.
//
// Ports:
//   clk_i         single clock, all state updates on the rising edge
//   rst_n_i       synchronous active-low reset
//   clear_i       synchronous flush of buffer and beat counter
//   fifo_empty_i  upstream FIFO empty flag
//   fifo_rdata_i  upstream FIFO show-ahead read data
//   fifo_ren_o    pop strobe to the upstream FIFO
//   out_valid_o   output beat available
//   out_data_o    output beat, zero when out_valid_o is low
//   out_ready_i   consumer accepts the beat when valid && ready
//   occupancy_o   entries held in the buffer (0..2)
//   beat_cnt_o    delivered-beat counter, wraps modulo 2^CNT_W
module nx_fifo_pop_stage #(
  parameter int WIDTH = 132,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_ren_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] beat_cnt_o
);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_s;
  logic             pop_s;

  // Pop the FIFO only when a slot is free; ready is deliberately not used so
  // the consumer never reaches the FIFO pointers combinationally.
  assign push_s = !fifo_empty_i && (count_q < 2'd2) && !clear_i && rst_n_i;
  assign pop_s  = (count_q != 2'd0) && out_ready_i;

  assign fifo_ren_o  = push_s;
  assign out_valid_o = (count_q != 2'd0);
  assign occupancy_o = count_q;
  assign beat_cnt_o  = cnt_q;

  // Output data mux: head entry when valid, zeros otherwise.
  always_comb begin
    out_data_o = {WIDTH{1'b0}};
    if (count_q != 2'd0) begin
      out_data_o = rptr_q ? entry1_q : entry0_q;
    end else begin
      out_data_o = {WIDTH{1'b0}};
    end
  end

  // Next-state for buffer pointers, count and beat counter.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      // A handshake coincident with clear is dropped and not counted.
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
      count_d = 2'd0;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        if (wptr_q) begin
          entry1_d = fifo_rdata_i;
        end else begin
          entry0_d = fifo_rdata_i;
        end
        wptr_d = ~wptr_q;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = ~rptr_q;
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      entry0_q <= {WIDTH{1'b0}};
      entry1_q <= {WIDTH{1'b0}};
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_nx_fifo_pop_stage.sv
// Testbench for nx_fifo_pop_stage: an array-backed show-ahead FIFO feeds the
// DUT; a queue model of the buffer predicts outputs every cycle; directed
// phases add literal expectations.
module tb_nx_fifo_pop_stage;
  localparam int W = 132;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, clear, out_ready;
  logic         fifo_empty;
  logic [W-1:0] fifo_rdata;
  logic         fifo_ren, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic [15:0]  beat_cnt;
  logic         fifo_ren4, out_valid4;
  logic [W-1:0] out_data4;
  logic [1:0]   occupancy4;
  logic [3:0]   beat_cnt4;

  logic [W-1:0] mem [0:2047];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int checks = 0;
  int errors = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_rdata = fifo_empty ? '0 : mem[rd_ptr[10:0]];

  nx_fifo_pop_stage #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
    .fifo_empty_i(fifo_empty), .fifo_rdata_i(fifo_rdata),
    .fifo_ren_o(fifo_ren), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_ready_i(out_ready), .occupancy_o(occupancy), .beat_cnt_o(beat_cnt));

  nx_fifo_pop_stage #(.WIDTH(W), .CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
    .fifo_empty_i(fifo_empty), .fifo_rdata_i(fifo_rdata),
    .fifo_ren_o(fifo_ren4), .out_valid_o(out_valid4), .out_data_o(out_data4),
    .out_ready_i(out_ready), .occupancy_o(occupancy4), .beat_cnt_o(beat_cnt4));

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    mem[wr_ptr[10:0]] = w;
    wr_ptr++;
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // Model: the buffer is a queue of at most two words; beats counted as integers.
  logic [W-1:0] mq [$];
  int unsigned  mcnt = 0;

  always @(posedge clk) begin : p_model
    logic         s_ren_dut, s_ren_exp, s_hs, s_clr, s_rst;
    logic [W-1:0] s_word;
    s_ren_dut = fifo_ren;
    s_rst     = rst_n;
    s_clr     = clear;
    s_ren_exp = (wr_ptr != rd_ptr) && (mq.size() < 2) && !s_clr && s_rst;
    s_hs      = (mq.size() != 0) && out_ready;
    s_word    = mem[rd_ptr[10:0]];
    #1;
    if (!s_rst || s_clr) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (s_hs) begin
        void'(mq.pop_front());
        mcnt++;
      end
      if (s_ren_exp) mq.push_back(s_word);
    end
    if (s_ren_dut && (wr_ptr != rd_ptr)) rd_ptr++;
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin : p_compare
    logic         e_ren;
    logic [W-1:0] e_data;
    #1;
    e_ren  = (wr_ptr != rd_ptr) && (mq.size() < 2) && !clear && rst_n;
    e_data = (mq.size() != 0) ? mq[0] : '0;
    check("ren", {131'b0, fifo_ren}, {131'b0, e_ren});
    check("valid", {131'b0, out_valid}, {131'b0, (mq.size() != 0)});
    check("data", out_data, e_data);
    check("occ", {130'b0, occupancy}, W'(mq.size()));
    check("beat_cnt", {116'b0, beat_cnt}, W'(mcnt[15:0]));
    check("beat_cnt4", {128'b0, beat_cnt4}, W'(mcnt[3:0]));
    check("data4", out_data4, e_data);
  end

  initial begin
    int pulses;
    int sent;
    bit done;
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) push_word(W'(i));

    // Reset with a non-empty FIFO: no pops.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      check("rst_ren", {131'b0, fifo_ren}, '0);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #2;
    check("rst_valid", {131'b0, out_valid}, '0);
    check("rst_data", out_data, '0);
    check("rst_occ", {130'b0, occupancy}, '0);
    check("rst_cnt", {116'b0, beat_cnt}, '0);
    check("first_ren", {131'b0, fifo_ren}, W'(1));

    // Streaming: 0x1..0x10 on consecutive cycles, first one edge after ren.
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #2;
      check("stream_valid", {131'b0, out_valid}, W'(1));
      check("stream_data", out_data, W'(i));
    end
    @(negedge clk); #2;
    check("stream_cnt", {116'b0, beat_cnt}, W'(16));
    check("stream_idle", {131'b0, out_valid}, '0);

    // Backpressure: exactly two pops, head word held.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      #2;
      if (fifo_ren) pulses++;
      @(negedge clk);
    end
    #2;
    check("bp_pulses", W'(pulses), W'(2));
    check("bp_occ", {130'b0, occupancy}, W'(2));
    check("bp_data", out_data, W'(1));
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    check("bp_cnt", {116'b0, beat_cnt}, W'(24));

    // Random ready with 1000 random words.
    sent = 0;
    done = 1'b0;
    for (int c = 0; c < 8000 && !done; c++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 1000 && $urandom_range(0, 1) == 1) begin
        push_word(rnd_word());
        sent++;
      end
      if (sent == 1000 && wr_ptr == rd_ptr && mq.size() == 0) done = 1'b1;
    end
    check("rand_done", {131'b0, done}, W'(1));
    #2;
    check("rand_cnt", {116'b0, beat_cnt}, W'(1024));

    // Clear with a full buffer and ready high.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(W'(32'h200 + i));
    repeat (4) @(negedge clk);
    #2;
    check("clr_occ_pre", {130'b0, occupancy}, W'(2));
    clear = 1'b1; out_ready = 1'b1;
    #1;
    check("clr_ren", {131'b0, fifo_ren}, '0);
    @(negedge clk);
    clear = 1'b0;
    #2;
    check("clr_valid", {131'b0, out_valid}, '0);
    check("clr_occ", {130'b0, occupancy}, '0);
    check("clr_cnt", {116'b0, beat_cnt}, '0);
    check("clr_resume", {131'b0, fifo_ren}, W'(1));
    repeat (8) @(negedge clk);
    #2;
    check("clr_cnt_after", {116'b0, beat_cnt}, W'(4));

    // Counter wrap on the 4-bit instance: 17 beats read as 1.
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 17; i++) push_word(W'(32'h300 + i));
    repeat (25) @(negedge clk);
    #2;
    check("wrap_cnt4", {128'b0, beat_cnt4}, W'(1));
    check("wrap_cnt16", {116'b0, beat_cnt}, W'(17));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
